// File: rtl/shift_arbiter_if.sv
// Request/response/shifter bundle shared between shift_arbiter (slave modport)
// and its surroundings: two requesters plus the external barrel shifter (master modport).
interface shift_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [4:0]  req0_shamt;
  logic [31:0] req0_data;
  logic [1:0]  req0_flag;

  logic        req1_valid;
  logic        req1_ready;
  logic [4:0]  req1_shamt;
  logic [31:0] req1_data;
  logic [1:0]  req1_flag;

  logic        resp0_valid;
  logic        resp0_ready;
  logic        resp1_valid;
  logic        resp1_ready;
  logic [31:0] resp_data;

  logic [4:0]  sh_a;
  logic [31:0] sh_b;
  logic [1:0]  sh_flag;
  logic [31:0] sh_s;

  logic        busy;

  modport slave (
    input  req0_valid, req0_shamt, req0_data, req0_flag,
    input  req1_valid, req1_shamt, req1_data, req1_flag,
    input  resp0_ready, resp1_ready, sh_s,
    output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data,
    output sh_a, sh_b, sh_flag, busy
  );

  modport master (
    output req0_valid, req0_shamt, req0_data, req0_flag,
    output req1_valid, req1_shamt, req1_data, req1_flag,
    output resp0_ready, resp1_ready, sh_s,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data,
    input  sh_a, sh_b, sh_flag, busy
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter/sequencer sharing one barrel shifter between two requesters.
// Optional `SHIFT_ARB_ZERO_BYPASS_EN: shamt==0 requests skip the shifter and respond one cycle earlier.
package shift_arbiter_pkg;
  typedef enum logic [1:0] {
    FLAG_SHIFT_SLL = 2'b00,
    FLAG_SHIFT_SRL = 2'b01,
    FLAG_SHIFT_SRA = 2'b11
  } shift_flag_e;
endpackage

module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter logic ARB_INIT = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  shift_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic        prio_q;
  logic        owner_q;
  logic [31:0] resp_data_q;
  logic [4:0]  sh_a_q;
  logic [31:0] sh_b_q;
  logic [1:0]  sh_flag_q;
  logic        resp0_valid_q;
  logic        resp1_valid_q;
  logic        busy_q;

  logic        grant_valid;
  logic        grant_idx;
  logic [4:0]  sel_shamt;
  logic [31:0] sel_data;
  logic [1:0]  sel_flag;
  logic        resp_done;
  logic        take_bypass;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 1'b0;
    if (state_q == IDLE) begin
      grant_valid = bus.req0_valid || bus.req1_valid;
      grant_idx   = (bus.req0_valid && bus.req1_valid) ? prio_q : bus.req1_valid;
    end

    sel_shamt = grant_idx ? bus.req1_shamt : bus.req0_shamt;
    sel_data  = grant_idx ? bus.req1_data  : bus.req0_data;
    sel_flag  = grant_idx ? bus.req1_flag  : bus.req0_flag;

    resp_done = owner_q ? (resp1_valid_q && bus.resp1_ready)
                        : (resp0_valid_q && bus.resp0_ready);
  end

`ifdef SHIFT_ARB_ZERO_BYPASS_EN
  assign take_bypass = (sel_shamt == 5'd0);
`else
  assign take_bypass = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      prio_q        <= ARB_INIT;
      owner_q       <= 1'b0;
      resp_data_q   <= 32'h0;
      sh_a_q        <= 5'd0;
      sh_b_q        <= 32'h0;
      sh_flag_q     <= FLAG_SHIFT_SLL;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_valid) begin
            sh_a_q    <= sel_shamt;
            sh_b_q    <= sel_data;
            sh_flag_q <= sel_flag;
            owner_q   <= grant_idx;
            prio_q    <= !grant_idx;
            busy_q    <= 1'b1;
            if (take_bypass) begin
              // A zero shift is the identity for every flag, so the operand is the result.
              resp_data_q   <= sel_data;
              resp0_valid_q <= !grant_idx;
              resp1_valid_q <= grant_idx;
              state_q       <= RESP;
            end else begin
              state_q <= EXEC;
            end
          end
        end
        EXEC: begin
          resp_data_q   <= bus.sh_s;
          resp0_valid_q <= !owner_q;
          resp1_valid_q <= owner_q;
          state_q       <= RESP;
        end
        RESP: begin
          if (resp_done) begin
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: begin
          resp0_valid_q <= 1'b0;
          resp1_valid_q <= 1'b0;
          busy_q        <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready  = grant_valid && !grant_idx;
  assign bus.req1_ready  = grant_valid &&  grant_idx;
  assign bus.resp0_valid = resp0_valid_q;
  assign bus.resp1_valid = resp1_valid_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.sh_a        = sh_a_q;
  assign bus.sh_b        = sh_b_q;
  assign bus.sh_flag     = sh_flag_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a behavioural shifter and a response scoreboard.
// Honours `SHIFT_ARB_ZERO_BYPASS_EN when choosing the zero-shift expectations.
module tb_shift_arbiter;
  import shift_arbiter_pkg::*;

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  shift_arbiter_if bus ();

  shift_arbiter #(.ARB_INIT(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural barrel shifter; the unused flag code 2'b10 yields zero.
  always_comb begin
    bus.sh_s = 32'h0;
    case (bus.sh_flag)
      FLAG_SHIFT_SLL: bus.sh_s = bus.sh_b << bus.sh_a;
      FLAG_SHIFT_SRL: bus.sh_s = bus.sh_b >> bus.sh_a;
      FLAG_SHIFT_SRA: bus.sh_s = $unsigned($signed(bus.sh_b) >>> bus.sh_a);
      default:        bus.sh_s = 32'h0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_req(input int n, input logic [4:0] sh, input logic [31:0] d, input logic [1:0] f);
    if (n == 0) begin
      bus.req0_valid = 1'b1; bus.req0_shamt = sh; bus.req0_data = d; bus.req0_flag = f;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_shamt = sh; bus.req1_data = d; bus.req1_flag = f;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req0_ready"},  32'(bus.req0_ready),  32'h0);
    check({tag, "_req1_ready"},  32'(bus.req1_ready),  32'h0);
    check({tag, "_resp0_valid"}, 32'(bus.resp0_valid), 32'h0);
    check({tag, "_resp1_valid"}, 32'(bus.resp1_valid), 32'h0);
    check({tag, "_busy"},        32'(bus.busy),        32'h0);
    check({tag, "_resp_data"},   bus.resp_data,        32'h0);
    check({tag, "_sh_a"},        32'(bus.sh_a),        32'h0);
    check({tag, "_sh_b"},        bus.sh_b,             32'h0);
    check({tag, "_sh_flag"},     32'(bus.sh_flag),     32'(FLAG_SHIFT_SLL));
  endtask

  // Scoreboard: every completed response handshake pops one expected result.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && ((bus.resp0_valid && bus.resp0_ready) || (bus.resp1_valid && bus.resp1_ready))) begin
      check("sb_pending", 32'(sb.size() > 0), 32'h1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_owner", 32'(bus.resp1_valid), 32'(e.owner));
        check("sb_data",  bus.resp_data,        e.data);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_shamt = 5'd0; bus.req0_data = 32'h0; bus.req0_flag = 2'b00;
    bus.req1_valid = 1'b0; bus.req1_shamt = 5'd0; bus.req1_data = 32'h0; bus.req1_flag = 2'b00;
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;

    repeat (3) tick();
    settle();
    check_reset_state("por");
    reset = 1'b0;

    // Lone req0, arithmetic right shift.
    drive_req(0, 5'd4, 32'hF000_0010, FLAG_SHIFT_SRA);
    settle();
    check("t1_req0_ready", 32'(bus.req0_ready), 32'h1);
    check("t1_req1_ready", 32'(bus.req1_ready), 32'h0);
    sb.push_back(exp_t'{1'b0, 32'hFF00_0001});
    tick();
    bus.req0_valid = 1'b0;
    settle();
    check("t1_exec_busy",   32'(bus.busy),        32'h1);
    check("t1_exec_valid",  32'(bus.resp0_valid), 32'h0);
    check("t1_sh_a",        32'(bus.sh_a),        32'd4);
    check("t1_sh_b",        bus.sh_b,             32'hF000_0010);
    check("t1_sh_flag",     32'(bus.sh_flag),     32'(FLAG_SHIFT_SRA));
    tick();
    bus.resp0_ready = 1'b1;
    settle();
    check("t1_resp0_valid", 32'(bus.resp0_valid), 32'h1);
    check("t1_resp1_valid", 32'(bus.resp1_valid), 32'h0);
    check("t1_resp_data",   bus.resp_data,        32'hFF00_0001);
    tick();
    bus.resp0_ready = 1'b0;
    settle();
    check("t1_idle_busy",   32'(bus.busy),        32'h0);
    check("t1_idle_valid",  32'(bus.resp0_valid), 32'h0);

    // Both requesters always valid after reset: grants alternate 0,1,0,1.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    drive_req(0, 5'd1, 32'd1, FLAG_SHIFT_SLL);
    drive_req(1, 5'd1, 32'd2, FLAG_SHIFT_SLL);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t2_req0_ready", 32'(bus.req0_ready), 32'(i % 2 == 0));
      check("t2_req1_ready", 32'(bus.req1_ready), 32'(i % 2 == 1));
      sb.push_back(exp_t'{1'(i % 2), (i % 2 == 1) ? 32'd4 : 32'd2});
      tick();
      tick();
      settle();
      check("t2_resp0_valid", 32'(bus.resp0_valid), 32'(i % 2 == 0));
      check("t2_resp1_valid", 32'(bus.resp1_valid), 32'(i % 2 == 1));
      check("t2_resp_data",   bus.resp_data,        (i % 2 == 1) ? 32'd4 : 32'd2);
      tick();
    end
    bus.req0_valid  = 1'b0;
    bus.req1_valid  = 1'b0;
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;

    // Req1 logical right by 31, response held for five cycles while req0 waits.
    drive_req(1, 5'd31, 32'h8000_0000, FLAG_SHIFT_SRL);
    settle();
    check("t3_req1_ready", 32'(bus.req1_ready), 32'h1);
    sb.push_back(exp_t'{1'b1, 32'h0000_0001});
    tick();
    bus.req1_valid = 1'b0;
    drive_req(0, 5'd3, 32'd5, FLAG_SHIFT_SLL);
    settle();
    check("t3_exec_req0_ready", 32'(bus.req0_ready), 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      settle();
      check("t3_hold_valid",      32'(bus.resp1_valid), 32'h1);
      check("t3_hold_data",       bus.resp_data,        32'h0000_0001);
      check("t3_hold_busy",       32'(bus.busy),        32'h1);
      check("t3_hold_req0_ready", 32'(bus.req0_ready),  32'h0);
      tick();
    end
    bus.resp1_ready = 1'b1;
    tick();
    bus.resp1_ready = 1'b0;
    settle();
    check("t3_pending_req0_ready", 32'(bus.req0_ready), 32'h1);
    sb.push_back(exp_t'{1'b0, 32'd40});
    bus.resp0_ready = 1'b1;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    settle();
    check("t3_req0_valid", 32'(bus.resp0_valid), 32'h1);
    check("t3_req0_data",  bus.resp_data,        32'd40);
    tick();
    bus.resp0_ready = 1'b0;

    // Reset asserted while in EXEC drops the operation.
    drive_req(0, 5'd1, 32'd3, FLAG_SHIFT_SLL);
    settle();
    check("t4_req0_ready", 32'(bus.req0_ready), 32'h1);
    tick();
    bus.req0_valid = 1'b0;
    reset = 1'b1;
    settle();
    check("t4_exec_busy", 32'(bus.busy), 32'h1);
    tick();
    reset = 1'b0;
    settle();
    check_reset_state("t4");
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t4_no_resp0", 32'(bus.resp0_valid), 32'h0);
      check("t4_no_resp1", 32'(bus.resp1_valid), 32'h0);
      tick();
    end
    bus.resp1_ready = 1'b0;

    // Unused flag 2'b10 with zero shift amount.
    drive_req(0, 5'd0, 32'h1234_5678, 2'b10);
    settle();
    check("t5_req0_ready", 32'(bus.req0_ready), 32'h1);
`ifdef SHIFT_ARB_ZERO_BYPASS_EN
    sb.push_back(exp_t'{1'b0, 32'h1234_5678});
    tick();
    bus.req0_valid = 1'b0;
    settle();
    check("t5_bypass_valid", 32'(bus.resp0_valid), 32'h1);
    check("t5_bypass_data",  bus.resp_data,        32'h1234_5678);
    tick();
`else
    sb.push_back(exp_t'{1'b0, 32'h0});
    tick();
    bus.req0_valid = 1'b0;
    settle();
    check("t5_exec_valid", 32'(bus.resp0_valid), 32'h0);
    tick();
    settle();
    check("t5_resp_valid", 32'(bus.resp0_valid), 32'h1);
    check("t5_resp_data",  bus.resp_data,        32'h0);
    tick();
`endif
    bus.resp0_ready = 1'b0;
    settle();
    check("t5_idle_busy", 32'(bus.busy), 32'h0);

    // Req1 pulses for one cycle during a held req0 response and is withdrawn.
    drive_req(0, 5'd2, 32'd1, FLAG_SHIFT_SLL);
    settle();
    check("t6_req0_ready", 32'(bus.req0_ready), 32'h1);
    sb.push_back(exp_t'{1'b0, 32'd4});
    tick();
    bus.req0_valid = 1'b0;
    tick();
    drive_req(1, 5'd1, 32'd7, FLAG_SHIFT_SLL);
    settle();
    check("t6_resp0_valid", 32'(bus.resp0_valid), 32'h1);
    check("t6_req1_ready",  32'(bus.req1_ready),  32'h0);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    bus.resp0_ready = 1'b1;
    tick();
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t6_idle_busy",  32'(bus.busy),        32'h0);
      check("t6_no_resp1",   32'(bus.resp1_valid), 32'h0);
      tick();
    end
    bus.resp1_ready = 1'b0;

    settle();
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
